// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: multi-cycle decimal ADC/SBC for the 6502 core.
// One BCD digit per cycle, then flags and a done pulse.
module bcd_alu_seq #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_sbc,
  input  logic [4*DIGITS-1:0] a_in,
  input  logic [4*DIGITS-1:0] b_in,
  input  logic                c_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                c_out,
  output logic                hc_out,
  output logic                n_out,
  output logic                v_out,
  output logic                z_out
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic         op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         c_q;
  logic [3:0]   lo_q;
  logic         lf_q;
  logic [3:0]   hi_q;
  logic         hf_q;
  logic         done_q;
  logic [W-1:0] res_q;
  logic         cf_q;
  logic         hcf_q;
  logic         nf_q;
  logic         vf_q;
  logic         zf_q;

  logic [4:0]   lo_step;
  logic [4:0]   hi_step;
  logic         hi_cin;
  logic [W-1:0] bp;
  logic [W-1:0] bsum;
  logic         v_bin;

  // Returns {carry-or-borrow, adjusted digit}.
  function automatic logic [4:0] dstep(
    input logic       sbc,
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       cin
  );
    logic [4:0]        s;
    logic signed [5:0] d;
    s = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    d = $signed({2'b00, x}) - $signed({2'b00, y})
        - $signed({5'd0, ~cin});
    if (sbc) begin
      if (d < 0) dstep = {1'b1, d[3:0] - 4'd6};
      else       dstep = {1'b0, d[3:0]};
    end else begin
      if (s > 5'd9) dstep = {1'b1, s[3:0] + 4'd6};
      else          dstep = {1'b0, s[3:0]};
    end
  endfunction

  // SBC carries "no borrow" into the next digit.
  assign hi_cin  = op_q ? ~lf_q : lf_q;
  assign lo_step = dstep(op_q, a_q[3:0], b_q[3:0], c_q);
  assign hi_step = dstep(op_q, a_q[W-1:W-4], b_q[W-1:W-4], hi_cin);

  assign bp    = op_q ? ~b_q : b_q;
  assign bsum  = a_q + bp + {{(W-1){1'b0}}, c_q};
  assign v_bin = (a_q[W-1] == bp[W-1]) && (bsum[W-1] != a_q[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LO;
      LO:   state_d = HI;
      HI:   state_d = FIN;
      FIN:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      lo_q   <= 4'd0;
      lf_q   <= 1'b0;
      hi_q   <= 4'd0;
      hf_q   <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      cf_q   <= 1'b0;
      hcf_q  <= 1'b0;
      nf_q   <= 1'b0;
      vf_q   <= 1'b0;
      zf_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FIN);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q <= op_sbc;
            a_q  <= a_in;
            b_q  <= b_in;
            c_q  <= c_in;
          end
        end
        LO: {lf_q, lo_q} <= lo_step;
        HI: {hf_q, hi_q} <= hi_step;
        FIN: begin
          res_q <= {hi_q, lo_q};
          cf_q  <= op_q ? ~hf_q : hf_q;
          hcf_q <= lf_q;
          nf_q  <= hi_q[3];
          vf_q  <= v_bin;
          zf_q  <= ({hi_q, lo_q} == 8'h00);
        end
      endcase
    end
  end

  assign result = res_q;
  assign c_out  = cf_q;
  assign hc_out = hcf_q;
  assign n_out  = nf_q;
  assign v_out  = vf_q;
  assign z_out  = zf_q;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb_bcd_alu_seq: directed vectors for bcd_alu_seq.
// Flags are compared as {c, hc, n, v, z}.
module tb_bcd_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       op_sbc;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       c_out;
  logic       hc_out;
  logic       n_out;
  logic       v_out;
  logic       z_out;

  int total = 0;
  int bad   = 0;
  int dcnt  = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done) dcnt++;

  bcd_alu_seq #(.DIGITS(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sbc (op_sbc),
    .a_in   (a_in),
    .b_in   (b_in),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .hc_out (hc_out),
    .n_out  (n_out),
    .v_out  (v_out),
    .z_out  (z_out)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return 32'({c_out, hc_out, n_out, v_out, z_out});
  endfunction

  task automatic run(
    input string      tag,
    input logic       s,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       c,
    input logic [7:0] er,
    input logic [4:0] ef
  );
    int cnt;
    int bz;
    @(negedge clk);
    op_sbc = s;
    a_in   = a;
    b_in   = b;
    c_in   = c;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    bz    = 0;
    while (cnt < 10) begin
      if (busy) bz++;
      if (done) break;
      @(negedge clk);
      cnt++;
    end
    check({tag, ".lat"},  32'(cnt), 32'd3);
    check({tag, ".busy"}, 32'(bz),  32'd3);
    check({tag, ".res"},  32'(result), 32'(er));
    check({tag, ".flg"},  flags(), 32'(ef));
  endtask

  initial begin
    int d0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sbc = 1'b0;
    a_in   = 8'h00;
    b_in   = 8'h00;
    c_in   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.res",  32'(result), 32'h00);
    check("rst.flg",  flags(), 32'd0);
    rst_n = 1'b1;

    run("adc45_38", 1'b0, 8'h45, 8'h38, 1'b0, 8'h83, 5'b01100);
    run("adc99_01", 1'b0, 8'h99, 8'h01, 1'b0, 8'h00, 5'b11001);
    run("sbc00_01", 1'b1, 8'h00, 8'h01, 1'b1, 8'h99, 5'b01100);
    run("sbc50_25", 1'b1, 8'h50, 8'h25, 1'b1, 8'h25, 5'b11000);
    run("adc25_25", 1'b0, 8'h25, 8'h25, 1'b1, 8'h51, 5'b01000);
    run("adc50_50", 1'b0, 8'h50, 8'h50, 1'b0, 8'h00, 5'b10011);
    run("sbc80_01", 1'b1, 8'h80, 8'h01, 1'b1, 8'h79, 5'b11010);
    run("adcAF_00", 1'b0, 8'hAF, 8'h00, 1'b0, 8'h15, 5'b11000);

    repeat (3) @(negedge clk);
    check("hold.res", 32'(result), 32'h15);
    check("hold.flg", flags(), 32'b11000);

    // Starts during LO and FIN must be ignored.
    d0 = dcnt;
    @(negedge clk);
    op_sbc = 1'b0;
    a_in   = 8'h12;
    b_in   = 8'h34;
    c_in   = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    op_sbc = 1'b1;
    a_in   = 8'h99;
    b_in   = 8'h99;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ign.fin_busy", 32'(busy), 32'd1);
    start = 1'b1;
    a_in  = 8'h77;
    @(negedge clk);
    start = 1'b0;
    check("ign.done", 32'(done), 32'd1);
    check("ign.idle", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("ign.pulses", 32'(dcnt - d0), 32'd1);
    check("ign.busy",   32'(busy), 32'd0);
    check("ign.res",    32'(result), 32'h46);
    check("ign.flg",    flags(), 32'd0);

    // Asynchronous reset during HI.
    @(negedge clk);
    op_sbc = 1'b0;
    a_in   = 8'h99;
    b_in   = 8'h99;
    c_in   = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar.busy", 32'(busy), 32'd0);
    check("ar.done", 32'(done), 32'd0);
    check("ar.res",  32'(result), 32'h00);
    check("ar.flg",  flags(), 32'd0);
    d0 = dcnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("ar.nodone", 32'(dcnt - d0), 32'd0);
    check("ar.idle",   32'(busy), 32'd0);

    run("adc09_08", 1'b0, 8'h09, 8'h08, 1'b0, 8'h17, 5'b01000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
